// File: rtl/minimig_zorro_base_decoder.sv
// -----------------------------------------------------------------------------
// minimig_zorro_base_decoder
//
// Works alongside the Minimig autoconfig ROM/sequencer. It snoops CPU writes
// into the autoconfig register window, captures the base address the OS
// assigns to each expansion board, and tracks whether each board has been
// committed or told to shut up. A registered, one-hot address decoder then
// steers CPU accesses to the Zorro II fast RAM (board 0) or one of up to
// three Zorro III RAM boards (boards 1-3).
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   clk7_en         7 MHz CPU-bus qualifier for autoconfig writes
//   address_in      CPU address [8:1] inside the autoconfig window
//   data_in         CPU write data
//   hwr, lwr        CPU high/low byte write strobes
//   sel             autoconfig window select
//   cfg_board       board currently answering autoconfig (0..3, 7 = chain end)
//   fastram_config  Zorro II RAM size: 00 off, 01 2 MB, 10 4 MB, 11 8 MB
//   cpu_addr        CPU address [31:16] to decode
//   cpu_req         CPU access request, qualifies the decode
//   board_valid     base committed, per board
//   board_shutup    board told to shut up, per board
//   board_hit       registered one-hot hit for cpu_addr (1 clk latency)
//   commit_pulse    one-clk pulse on any commit or shut-up
//   zii_base        captured A23..A16 of the Zorro II board
//   ziii_base1..3   captured A31..A16 of Zorro III boards 1..3
// -----------------------------------------------------------------------------
module minimig_zorro_base_decoder #(
    parameter int ZIII1_SIZE_LOG2 = 25,
    parameter int ZIII2_SIZE_LOG2 = 25,
    parameter int ZIII3_SIZE_LOG2 = 22   // legal range 16..25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [7:0]  address_in,
    input  logic [15:0] data_in,
    input  logic        hwr,
    input  logic        lwr,
    input  logic        sel,
    input  logic [2:0]  cfg_board,
    input  logic [1:0]  fastram_config,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_req,
    output logic [3:0]  board_valid,
    output logic [3:0]  board_shutup,
    output logic [3:0]  board_hit,
    output logic        commit_pulse,
    output logic [7:0]  zii_base,
    output logic [15:0] ziii_base1,
    output logic [15:0] ziii_base2,
    output logic [15:0] ziii_base3
);

    // address_in carries A8..A1, so each register sits at its byte offset / 2.
    localparam logic [7:0] REG_ZIII_BASE = 8'h22;  // byte offset 0x44
    localparam logic [7:0] REG_ZII_HI    = 8'h24;  // byte offset 0x48
    localparam logic [7:0] REG_ZII_LO    = 8'h25;  // byte offset 0x4A
    localparam logic [7:0] REG_SHUTUP    = 8'h26;  // byte offset 0x4C

    // Address bits above the board size take part in the compare.
    localparam logic [15:0] ZIII1_MASK = 16'hFFFF << (ZIII1_SIZE_LOG2 - 16);
    localparam logic [15:0] ZIII2_MASK = 16'hFFFF << (ZIII2_SIZE_LOG2 - 16);
    localparam logic [15:0] ZIII3_MASK = 16'hFFFF << (ZIII3_SIZE_LOG2 - 16);

    // One-hot per-board lifecycle; VALID and SHUTUP are both terminal.
    typedef enum logic [2:0] {
        ST_UNCONF = 3'b001,
        ST_VALID  = 3'b010,
        ST_SHUTUP = 3'b100
    } board_state_t;

    board_state_t state [4];
    logic [3:0]   zii_nibble;   // A19..A16 written ahead of the 0x48 commit
    logic         zii_pend;
    logic [1:0]   idx;
    logic         wr_evt;
    logic         wr_ok;
    logic [7:0]   zii_mask;
    logic [3:0]   raw_hit;
    logic [3:0]   hit_next;

    assign idx    = cfg_board[1:0];
    assign wr_evt = clk7_en & sel & (hwr | lwr);
    // Only boards 0..3 that are still unconfigured accept writes, which makes
    // repeat commits and shut-ups of already-settled boards no-ops.
    assign wr_ok  = wr_evt & ~cfg_board[2] & (state[idx] == ST_UNCONF);

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            board_valid[n]  = (state[n] == ST_VALID);
            board_shutup[n] = (state[n] == ST_SHUTUP);
        end
    end

    // Zorro II RAM is aligned to its own size, so only A23..k are compared.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        zii_mask = 8'h00;
        case (fastram_config)
            2'b01:   zii_mask = 8'hE0;   // 2 MB: A23..A21
            2'b10:   zii_mask = 8'hC0;   // 4 MB: A23..A22
            2'b11:   zii_mask = 8'h80;   // 8 MB: A23
            default: zii_mask = 8'h00;
        endcase
    end

    always_comb begin
        raw_hit    = 4'b0000;
        raw_hit[0] = board_valid[0] & cpu_req & (fastram_config != 2'b00) &
                     (cpu_addr[15:8] == 8'h00) &
                     (((cpu_addr[7:0] ^ zii_base) & zii_mask) == 8'h00);
        raw_hit[1] = board_valid[1] & cpu_req &
                     (((cpu_addr ^ ziii_base1) & ZIII1_MASK) == 16'h0000);
        raw_hit[2] = board_valid[2] & cpu_req &
                     (((cpu_addr ^ ziii_base2) & ZIII2_MASK) == 16'h0000);
        raw_hit[3] = board_valid[3] & cpu_req &
                     (((cpu_addr ^ ziii_base3) & ZIII3_MASK) == 16'h0000);
    end

    // Overlapping bases from a bad OS assignment resolve to the lowest board.
    always_comb begin
        hit_next = 4'b0000;
        if (raw_hit[0])      hit_next = 4'b0001;
        else if (raw_hit[1]) hit_next = 4'b0010;
        else if (raw_hit[2]) hit_next = 4'b0100;
        else if (raw_hit[3]) hit_next = 4'b1000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every register is reset here, including the pending nibble,
            // so a reset between the 0x4A and 0x48 writes discards the nibble.
            for (int n = 0; n < 4; n++) state[n] <= ST_UNCONF;
            zii_nibble   <= 4'h0;
            zii_pend     <= 1'b0;
            board_hit    <= 4'b0000;
            commit_pulse <= 1'b0;
            zii_base     <= 8'h00;
            ziii_base1   <= 16'h0000;
            ziii_base2   <= 16'h0000;
            ziii_base3   <= 16'h0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            commit_pulse <= 1'b0;
            board_hit    <= hit_next;   // decode runs every clk, not on clk7_en

            if (wr_ok) begin
                case (address_in)
                    REG_ZII_LO: begin
                        if (idx == 2'd0) begin
                            zii_nibble <= lwr ? data_in[7:4] : data_in[15:12];
                            zii_pend   <= 1'b1;
                        end
                    end
                    REG_ZII_HI: begin
                        if (idx == 2'd0 && hwr) begin
                            zii_base     <= {data_in[15:12], zii_pend ? zii_nibble : 4'h0};
                            zii_pend     <= 1'b0;
                            state[0]     <= ST_VALID;
                            commit_pulse <= 1'b1;
                        end
                    end
                    REG_ZIII_BASE: begin
                        if (idx != 2'd0 && hwr) begin
                            // A high-byte-only write stages the upper byte; a
                            // full word write captures the base and commits.
                            case (idx)
                                2'd1: begin
                                    if (lwr) ziii_base1 <= data_in;
                                    else     ziii_base1[15:8] <= data_in[15:8];
                                end
                                2'd2: begin
                                    if (lwr) ziii_base2 <= data_in;
                                    else     ziii_base2[15:8] <= data_in[15:8];
                                end
                                default: begin
                                    if (lwr) ziii_base3 <= data_in;
                                    else     ziii_base3[15:8] <= data_in[15:8];
                                end
                            endcase
                            if (lwr) begin
                                state[idx]   <= ST_VALID;
                                commit_pulse <= 1'b1;
                            end
                        end
                    end
                    REG_SHUTUP: begin
                        state[idx]   <= ST_SHUTUP;
                        commit_pulse <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_minimig_zorro_base_decoder.sv
// -----------------------------------------------------------------------------
// Testbench for minimig_zorro_base_decoder: a table of write/decode vectors
// applied in a loop with expected state pushed to a scoreboard queue, plus
// hand-written sequences for decode latency and sparse clk7_en commits.
// -----------------------------------------------------------------------------
module tb_minimig_zorro_base_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic [7:0]  address_in;
    logic [15:0] data_in;
    logic        hwr;
    logic        lwr;
    logic        sel;
    logic [2:0]  cfg_board;
    logic [1:0]  fastram_config;
    logic [15:0] cpu_addr;
    logic        cpu_req;
    logic [3:0]  board_valid;
    logic [3:0]  board_shutup;
    logic [3:0]  board_hit;
    logic        commit_pulse;
    logic [7:0]  zii_base;
    logic [15:0] ziii_base1;
    logic [15:0] ziii_base2;
    logic [15:0] ziii_base3;

    minimig_zorro_base_decoder dut (
        .clk            (clk),
        .reset          (reset),
        .clk7_en        (clk7_en),
        .address_in     (address_in),
        .data_in        (data_in),
        .hwr            (hwr),
        .lwr            (lwr),
        .sel            (sel),
        .cfg_board      (cfg_board),
        .fastram_config (fastram_config),
        .cpu_addr       (cpu_addr),
        .cpu_req        (cpu_req),
        .board_valid    (board_valid),
        .board_shutup   (board_shutup),
        .board_hit      (board_hit),
        .commit_pulse   (commit_pulse),
        .zii_base       (zii_base),
        .ziii_base1     (ziii_base1),
        .ziii_base2     (ziii_base2),
        .ziii_base3     (ziii_base3)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] A_44 = 8'h22;
    localparam logic [7:0] A_48 = 8'h24;
    localparam logic [7:0] A_4A = 8'h25;
    localparam logic [7:0] A_4C = 8'h26;
    localparam logic [7:0] A_50 = 8'h28;

    typedef struct packed {
        logic [3:0]  valid;
        logic [3:0]  shutup;
        logic [3:0]  hit;
        logic [7:0]  zii;
        logic [15:0] b1;
        logic [15:0] b2;
        logic [15:0] b3;
    } out_t;

    typedef struct {
        bit          rst;
        bit          wr;
        logic [2:0]  cfg;
        logic [7:0]  adr;
        logic [15:0] dat;
        bit          hw;
        bit          lw;
        logic [1:0]  fcfg;
        logic [15:0] caddr;
        bit          creq;
        bit          exp_pulse;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];
    out_t sb_q[$];
    out_t act;
    out_t exp_o;
    vec_t v;
    int   checks   = 0;
    int   failures = 0;
    int   pulses;
    bit   seen;

    assign act = {board_valid, board_shutup, board_hit, zii_base,
                  ziii_base1, ziii_base2, ziii_base3};

    task automatic check(input string name, input logic [67:0] actual,
                         input logic [67:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic add(input bit rst, input bit wr, input logic [2:0] cfg,
                       input logic [7:0] adr, input logic [15:0] dat,
                       input bit hw, input bit lw, input logic [1:0] fcfg,
                       input logic [15:0] caddr, input bit creq, input bit ep,
                       input logic [3:0] ev, input logic [3:0] es,
                       input logic [3:0] eh, input logic [7:0] ez,
                       input logic [15:0] e1, input logic [15:0] e2,
                       input logic [15:0] e3);
        vec_t t;
        t.rst = rst; t.wr = wr; t.cfg = cfg; t.adr = adr; t.dat = dat;
        t.hw = hw; t.lw = lw; t.fcfg = fcfg; t.caddr = caddr; t.creq = creq;
        t.exp_pulse = ep;
        t.exp = '{valid: ev, shutup: es, hit: eh, zii: ez, b1: e1, b2: e2, b3: e3};
        vecs.push_back(t);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic idle_bus();
        clk7_en = 1'b0; sel = 1'b0; hwr = 1'b0; lwr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clk7_en = 1'b0; address_in = 8'h00; data_in = 16'h0000;
        hwr = 1'b0; lwr = 1'b0; sel = 1'b0; cfg_board = 3'd7;
        fastram_config = 2'b11; cpu_addr = 16'h0000; cpu_req = 1'b0;

        //  rst wr cfg adr   dat      hw lw fc  caddr     rq p  valid   shutup  hit     zii    b1        b2        b3
        add(1, 0, 0, A_44, 16'h0000, 0, 0, 3, 16'h0000, 0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0000);
        add(0, 1, 0, A_4A, 16'h00A0, 0, 1, 3, 16'h0000, 0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0000);
        add(0, 1, 0, A_48, 16'h2000, 1, 0, 3, 16'h0020, 1, 1, 4'h1, 4'h0, 4'h1, 8'h2A, 16'h0000, 16'h0000, 16'h0000);
        add(0, 0, 0, A_44, 16'h0000, 0, 0, 3, 16'h0080, 1, 0, 4'h1, 4'h0, 4'h0, 8'h2A, 16'h0000, 16'h0000, 16'h0000);
        add(0, 0, 0, A_44, 16'h0000, 0, 0, 1, 16'h0040, 1, 0, 4'h1, 4'h0, 4'h0, 8'h2A, 16'h0000, 16'h0000, 16'h0000);
        add(0, 0, 0, A_44, 16'h0000, 0, 0, 1, 16'h003F, 1, 0, 4'h1, 4'h0, 4'h1, 8'h2A, 16'h0000, 16'h0000, 16'h0000);
        add(0, 0, 0, A_44, 16'h0000, 0, 0, 0, 16'h0020, 1, 0, 4'h1, 4'h0, 4'h0, 8'h2A, 16'h0000, 16'h0000, 16'h0000);
        add(0, 0, 0, A_44, 16'h0000, 0, 0, 3, 16'h0120, 1, 0, 4'h1, 4'h0, 4'h0, 8'h2A, 16'h0000, 16'h0000, 16'h0000);
        add(0, 1, 1, A_44, 16'h4000, 1, 1, 3, 16'h41FF, 1, 1, 4'h3, 4'h0, 4'h2, 8'h2A, 16'h4000, 16'h0000, 16'h0000);
        add(0, 0, 1, A_44, 16'h0000, 0, 0, 3, 16'h4200, 1, 0, 4'h3, 4'h0, 4'h0, 8'h2A, 16'h4000, 16'h0000, 16'h0000);
        add(0, 1, 2, A_4C, 16'h0000, 1, 1, 3, 16'h0000, 0, 1, 4'h3, 4'h4, 4'h0, 8'h2A, 16'h4000, 16'h0000, 16'h0000);
        add(0, 1, 2, A_44, 16'h5000, 1, 1, 3, 16'h0000, 0, 0, 4'h3, 4'h4, 4'h0, 8'h2A, 16'h4000, 16'h0000, 16'h0000);
        add(0, 1, 1, A_44, 16'h6000, 1, 1, 3, 16'h0000, 0, 0, 4'h3, 4'h4, 4'h0, 8'h2A, 16'h4000, 16'h0000, 16'h0000);
        add(0, 1, 1, A_4C, 16'h0000, 1, 1, 3, 16'h0000, 0, 0, 4'h3, 4'h4, 4'h0, 8'h2A, 16'h4000, 16'h0000, 16'h0000);
        add(0, 1, 3, A_44, 16'h7711, 1, 0, 3, 16'h0000, 0, 0, 4'h3, 4'h4, 4'h0, 8'h2A, 16'h4000, 16'h0000, 16'h7700);
        add(0, 1, 3, A_44, 16'h8040, 1, 1, 3, 16'h8043, 1, 1, 4'hB, 4'h4, 4'h8, 8'h2A, 16'h4000, 16'h0000, 16'h8040);
        add(0, 0, 3, A_44, 16'h0000, 0, 0, 3, 16'h8080, 1, 0, 4'hB, 4'h4, 4'h0, 8'h2A, 16'h4000, 16'h0000, 16'h8040);
        add(0, 1, 7, A_44, 16'h1234, 1, 1, 3, 16'h0000, 0, 0, 4'hB, 4'h4, 4'h0, 8'h2A, 16'h4000, 16'h0000, 16'h8040);
        add(0, 1, 7, A_48, 16'h1234, 1, 0, 3, 16'h0000, 0, 0, 4'hB, 4'h4, 4'h0, 8'h2A, 16'h4000, 16'h0000, 16'h8040);
        add(1, 1, 1, A_44, 16'h4000, 1, 1, 3, 16'h0000, 0, 1, 4'h2, 4'h0, 4'h0, 8'h00, 16'h4000, 16'h0000, 16'h0000);
        add(0, 1, 2, A_50, 16'h1234, 1, 1, 3, 16'h0000, 0, 0, 4'h2, 4'h0, 4'h0, 8'h00, 16'h4000, 16'h0000, 16'h0000);
        add(0, 1, 2, A_44, 16'h4000, 1, 1, 3, 16'h4000, 1, 1, 4'h6, 4'h0, 4'h2, 8'h00, 16'h4000, 16'h4000, 16'h0000);
        add(0, 1, 0, A_4A, 16'hB000, 1, 0, 3, 16'h4000, 1, 0, 4'h6, 4'h0, 4'h2, 8'h00, 16'h4000, 16'h4000, 16'h0000);
        add(1, 1, 0, A_48, 16'h3000, 1, 0, 3, 16'h0030, 1, 1, 4'h1, 4'h0, 4'h1, 8'h30, 16'h0000, 16'h0000, 16'h0000);
        add(1, 1, 0, A_4A, 16'hB000, 1, 0, 3, 16'h0000, 0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0000);
        add(0, 1, 0, A_48, 16'h5000, 0, 1, 3, 16'h0000, 0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0000);
        add(0, 1, 0, A_48, 16'h5000, 1, 0, 3, 16'h0000, 0, 1, 4'h1, 4'h0, 4'h0, 8'h5B, 16'h0000, 16'h0000, 16'h0000);

        // Each vector: one write cycle (commit_pulse sampled after it), then
        // one idle cycle so the registered decode sees the updated state.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst) do_reset();
            clk7_en        = v.wr;
            sel            = v.wr;
            hwr            = v.wr & v.hw;
            lwr            = v.wr & v.lw;
            cfg_board      = v.cfg;
            address_in     = v.adr;
            data_in        = v.dat;
            fastram_config = v.fcfg;
            cpu_addr       = v.caddr;
            cpu_req        = v.creq;
            sb_q.push_back(v.exp);
            @(posedge clk); #1;
            check($sformatf("vec%0d commit_pulse", i), {67'd0, commit_pulse},
                  {67'd0, v.exp_pulse});
            idle_bus();
            @(posedge clk); #1;
            exp_o = sb_q.pop_front();
            check($sformatf("vec%0d outputs", i), act, exp_o);
            check($sformatf("vec%0d pulse_cleared", i), {67'd0, commit_pulse}, 68'd0);
        end

        // Decode latency: a new cpu_addr shows up on board_hit one clk later.
        do_reset();
        cfg_board = 3'd1; address_in = A_44; data_in = 16'h4000;
        clk7_en = 1'b1; sel = 1'b1; hwr = 1'b1; lwr = 1'b1;
        @(posedge clk); #1;
        idle_bus();
        cpu_addr = 16'h41FF; cpu_req = 1'b1;
        #2;
        check("latency before edge", {64'd0, board_hit}, 68'd0);
        @(posedge clk); #1;
        check("latency after edge", {64'd0, board_hit}, {64'd0, 4'b0010});
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("hit drops with cpu_req", {64'd0, board_hit}, 68'd0);

        // Sparse clk7_en with the write held: exactly one commit pulse,
        // found within a bounded cycle budget.
        do_reset();
        cfg_board = 3'd2; address_in = A_44; data_in = 16'h9000;
        sel = 1'b1; hwr = 1'b1; lwr = 1'b1;
        pulses = 0; seen = 1'b0;
        for (int c = 0; c < 16; c++) begin
            clk7_en = (c % 4 == 3);
            @(posedge clk); #1;
            if (commit_pulse) begin
                pulses++;
                seen = 1'b1;
            end
        end
        idle_bus();
        check("sparse commit seen", {67'd0, seen}, {67'd0, 1'b1});
        check("sparse pulse count", {36'd0, pulses}, 68'd1);
        check("sparse base2", {52'd0, ziii_base2}, {52'd0, 16'h9000});
        check("sparse valid", {64'd0, board_valid}, {64'd0, 4'b0100});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minimig_zorro_base_decoder.md
Name: minimig_zorro_base_decoder

Overview:
- Companion controller to the Minimig autoconfig ROM/sequencer.
- Watches CPU writes to the autoconfig register window and captures the base address the OS assigns to each board.
- Tracks the commit and shut-up state of every board.
- Drives registered per-board address-hit strobes that steer CPU accesses to Zorro II fast RAM (board 0) and up to three Zorro III RAM boards (boards 1-3) in the SDRAM arbiter.

Parameters:
- ZIII1_SIZE_LOG2, 25, byte-size log2 of ZIII board 1 (32 MB).
- ZIII2_SIZE_LOG2, 25, byte-size log2 of ZIII board 2 (32 MB).
- ZIII3_SIZE_LOG2, 22, byte-size log2 of ZIII board 3 (4 MB); legal range 16..25.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk7_en  in  1  7 MHz CPU-bus qualifier
- address_in  in  8  CPU address [8:1] within the autoconfig window
- data_in  in  16  CPU write data
- hwr  in  1  CPU high-byte write
- lwr  in  1  CPU low-byte write
- sel  in  1  autoconfig window select
- cfg_board  in  3  board currently answering autoconfig (0..3; 7 = chain end)
- fastram_config  in  2  ZII RAM size: 00 off, 01 2 MB, 10 4 MB, 11 8 MB
- cpu_addr  in  16  CPU address [31:16] for decode
- cpu_req  in  1  CPU access request, qualifies decode
- board_valid  out  4  base committed for board n
- board_shutup  out  4  board n told to shut up
- board_hit  out  4  registered one-hot hit for the current cpu_addr
- commit_pulse  out  1  one-clk pulse on any commit or shut-up
- zii_base  out  8  captured A23..A16 of ZII board
- ziii_base1  out  16  captured A31..A16, board 1
- ziii_base2  out  16  captured A31..A16, board 2
- ziii_base3  out  16  captured A31..A16, board 3

Behaviour:
- Reset: all outputs 0, nibble latch 0, `zii_pend` = 0.
- A bus write event is `clk7_en & sel & (hwr|lwr)`. Only write events with `cfg_board` 0..3 are acted on; `cfg_board` = 7 ignores all writes.
- Board state per board is a one-hot FSM: UNCONF → VALID or UNCONF → SHUTUP. Both terminal states persist until reset. A second commit to a VALID board is ignored; the base is not overwritten.
- ZII (`cfg_board` = 0):
  - Write to 0x4A with `lwr`: latch `data_in[7:4]` as A19..A16 and set `zii_pend`.
  - Write to 0x4A with only `hwr`: latch `data_in[15:12]` as A19..A16 and set `zii_pend`.
  - Write to 0x48 with `hwr`: `zii_base` = {`data_in[15:12]`, latched nibble}, or {`data_in[15:12]`, 4'h0} if `zii_pend` = 0. Then set `board_valid[0]`, clear `zii_pend`, pulse `commit_pulse`.
  - Write to 0x48 with `lwr` only: ignored.
- ZIII (`cfg_board` 1..3): write to 0x44 with `hwr` and `lwr` → `ziii_baseN` = `data_in`, set `board_valid[N]`, pulse `commit_pulse`. A byte write (`hwr` only) updates `ziii_baseN[15:8]` without committing.
- Shut-up: write to 0x4C for board n → set `board_shutup[n]`, pulse `commit_pulse`; no effect if `board_valid[n]` is already set.
- Decode is registered, 1 clk latency, and updates every clk (not gated by `clk7_en`):
  - `board_hit[0]` = `valid[0]` & `cpu_req` & `fastram_config` != 0 & `cpu_addr[31:24]` == 0 & `cpu_addr[23:k]` == `zii_base[7:k-16]`, where k = 21/22/23 for 2/4/8 MB.
  - `board_hit[N]` (N = 1..3) = `valid[N]` & `cpu_req` & `cpu_addr[31:S]` == `ziii_baseN[15:S-16]`, with S = ZIIIN_SIZE_LOG2.
  - If several boards match (overlap from a bad OS assignment), only the lowest index is asserted; `board_hit` is always one-hot or zero.
- `fastram_config` changing to 00 at runtime forces `board_hit[0]` = 0 next clk; `board_valid[0]` is unchanged.
- Reset mid-sequence (between the 0x4A and 0x48 writes) discards the pending nibble.
- Writes to any other offset have no effect.

Test Plan:
- Reset, then `cfg_board` = 0, `fastram_config` = 11: write 0x4A `lwr` `data_in` = 0x00A0, then 0x48 `hwr` `data_in` = 0x2000 → `zii_base` = 0x2A, `board_valid` = 0001, `commit_pulse` high exactly 1 clk. Then `cpu_addr` = 0x0020, `cpu_req` = 1 → `board_hit` = 0001 one clk later; `cpu_addr` = 0x0080 → 0000.
- `cfg_board` = 1: word write 0x44 `data_in` = 0x4000 → `ziii_base1` = 0x4000. `cpu_addr` 0x41FF hits board 1; 0x4200 misses.
- `cfg_board` = 2: write 0x4C → `board_shutup` = 0100, `board_valid[2]` = 0; a later 0x44 write to board 2 is ignored.
- Overlap: `ziii_base1` = `ziii_base2` = 0x4000, both valid, `cpu_addr` = 0x4000 → `board_hit` = 0010.
- `cfg_board` = 7: writes to 0x44/0x48 → no state change; `cpu_req` = 0 → `board_hit` = 0000.
- 0x4A written, reset asserted, then 0x48 `data_in` = 0x3000 → `zii_base` = 0x30.
